// File: rtl/lynx_tap_loader.sv
// rtl/lynx_tap_loader.sv - Lynx TAP image parser loading multi-block cassette data into RAM
module lynx_tap_loader #(
   parameter int          ADDR_W       = 16,
   parameter logic [15:0] DEFAULT_LOAD = 16'h694D,
   parameter bit          FORCE_LOAD   = 1'b0,
   parameter logic [7:0]  BASIC_TYPE   = 8'h42,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic              ioctl_wait,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_dout,
   output logic              mem_wr,
   input  logic              mem_ack,
   output logic [7:0]        file_type,
   output logic [15:0]       exec_addr,
   output logic              exec_valid,
   output logic [3:0]        block_cnt,
   output logic              busy,
   output logic              done,
   output logic              chk_err,
   output logic              fmt_err
);

   typedef enum logic [3:0] {
      S_IDLE, S_SEEK, S_NAME, S_TYPE, S_LENLO, S_LENHI, S_LDLO,
      S_LDHI, S_EXLO, S_EXHI, S_DATA, S_CHK, S_TAIL
   } state_t;

   state_t             state_q, state_d;
   logic               dl_q;
   logic               end_pend_q, end_pend_d;
   logic               skid_full_q, skid_full_d;
   logic [7:0]         skid_data_q, skid_data_d;
   logic [7:0]         tmp_q, tmp_d;
   logic signed [16:0] cnt_q, cnt_d;
   logic [7:0]         sum_q, sum_d;
   logic [ADDR_W-1:0]  ptr_q, ptr_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic [7:0]         mem_dout_q, mem_dout_d;
   logic               mem_wr_q, mem_wr_d;
   logic [7:0]         file_type_q, file_type_d;
   logic [15:0]        exec_addr_q, exec_addr_d;
   logic               exec_valid_q, exec_valid_d;
   logic [3:0]         block_cnt_q, block_cnt_d;
   logic               done_q, done_d;
   logic               chk_err_q, chk_err_d;
   logic               fmt_err_q, fmt_err_d;

   logic               dl_rise, dl_fall, wr_in, take_skid, take_in, consume;
   logic [7:0]         byte_in;
   logic               unused_addr;

   assign unused_addr = ^ioctl_addr;

   assign dl_rise   = ioctl_download & ~dl_q;
   assign dl_fall   = ~ioctl_download & dl_q;
   assign wr_in     = ioctl_wr & ioctl_download;
   // The skid byte was accepted earlier, so it always takes priority over a new strobe.
   assign take_skid = skid_full_q & ~mem_wr_q;
   assign take_in   = wr_in & ~mem_wr_q & ~skid_full_q;
   assign consume   = take_skid | take_in;
   assign byte_in   = take_skid ? skid_data_q : ioctl_dout;

   always_comb begin
      state_d      = state_q;
      end_pend_d   = end_pend_q;
      skid_full_d  = skid_full_q;
      skid_data_d  = skid_data_q;
      tmp_d        = tmp_q;
      cnt_d        = cnt_q;
      sum_d        = sum_q;
      ptr_d        = ptr_q;
      mem_addr_d   = mem_addr_q;
      mem_dout_d   = mem_dout_q;
      mem_wr_d     = mem_wr_q;
      file_type_d  = file_type_q;
      exec_addr_d  = exec_addr_q;
      exec_valid_d = 1'b0;
      block_cnt_d  = block_cnt_q;
      done_d       = done_q;
      chk_err_d    = chk_err_q;
      fmt_err_d    = fmt_err_q;

      if (mem_wr_q && mem_ack) mem_wr_d = 1'b0;

      if (dl_rise) begin
         state_d     = S_SEEK;
         end_pend_d  = 1'b0;
         skid_full_d = 1'b0;
         sum_d       = 8'h00;
         block_cnt_d = 4'h0;
         done_d      = 1'b0;
         chk_err_d   = 1'b0;
         fmt_err_d   = 1'b0;
      end else begin
         if (dl_fall) end_pend_d = 1'b1;
         if (wr_in && (mem_wr_q || skid_full_q)) begin
            if (skid_full_q) begin
               fmt_err_d = 1'b1;
            end else begin
               skid_full_d = 1'b1;
               skid_data_d = ioctl_dout;
            end
         end
         if (take_skid) skid_full_d = 1'b0;

         if (consume) begin
            case (state_q)
               S_SEEK: if (byte_in == 8'h22) state_d = S_NAME;
               S_NAME: if (byte_in == 8'h22) state_d = S_TYPE;
               S_TYPE: if (byte_in != SYNC_BYTE) begin
                  file_type_d = byte_in;
                  state_d     = S_LENLO;
               end
               S_LENLO: begin
                  tmp_d   = byte_in;
                  state_d = S_LENHI;
               end
               S_LENHI: begin
                  if (file_type_q == BASIC_TYPE) begin
                     cnt_d   = $signed({1'b0, byte_in, tmp_q}) - 17'sd1;
                     ptr_d   = ADDR_W'(DEFAULT_LOAD);
                     state_d = (cnt_d <= 17'sd0) ? S_CHK : S_DATA;
                  end else begin
                     cnt_d   = $signed({1'b0, byte_in, tmp_q}) - 17'sd3;
                     state_d = S_LDLO;
                  end
               end
               S_LDLO: begin
                  tmp_d   = byte_in;
                  state_d = S_LDHI;
               end
               S_LDHI: begin
                  ptr_d   = FORCE_LOAD ? ADDR_W'(DEFAULT_LOAD) : ADDR_W'({byte_in, tmp_q});
                  state_d = S_EXLO;
               end
               S_EXLO: begin
                  tmp_d   = byte_in;
                  state_d = S_EXHI;
               end
               S_EXHI: begin
                  exec_addr_d  = {byte_in, tmp_q};
                  exec_valid_d = 1'b1;
                  state_d      = (cnt_q <= 17'sd0) ? S_CHK : S_DATA;
               end
               S_DATA: begin
                  mem_wr_d   = 1'b1;
                  mem_addr_d = ptr_q;
                  mem_dout_d = byte_in;
                  ptr_d      = ptr_q + ADDR_W'(1);
                  sum_d      = sum_q + byte_in;
                  cnt_d      = cnt_q - 17'sd1;
                  if (cnt_q == 17'sd1) state_d = S_CHK;
               end
               S_CHK: begin
                  if (byte_in != sum_q) chk_err_d = 1'b1;
                  state_d = S_TAIL;
               end
               S_TAIL: begin
                  if (block_cnt_q != 4'hF) block_cnt_d = block_cnt_q + 4'h1;
                  sum_d   = 8'h00;
                  state_d = S_SEEK;
               end
               default: ;
            endcase
         end

         // Wrap-up waits until the skid byte has been parsed so it still lands in RAM.
         if (end_pend_q && !skid_full_q) begin
            end_pend_d = 1'b0;
            if (state_q != S_SEEK && state_q != S_IDLE) fmt_err_d = 1'b1;
            state_d = S_IDLE;
            done_d  = (block_cnt_q != 4'h0);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         dl_q         <= 1'b0;
         end_pend_q   <= 1'b0;
         skid_full_q  <= 1'b0;
         skid_data_q  <= 8'h00;
         tmp_q        <= 8'h00;
         cnt_q        <= 17'sd0;
         sum_q        <= 8'h00;
         ptr_q        <= '0;
         mem_addr_q   <= '0;
         mem_dout_q   <= 8'h00;
         mem_wr_q     <= 1'b0;
         file_type_q  <= 8'h00;
         exec_addr_q  <= 16'h0000;
         exec_valid_q <= 1'b0;
         block_cnt_q  <= 4'h0;
         done_q       <= 1'b0;
         chk_err_q    <= 1'b0;
         fmt_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         dl_q         <= ioctl_download;
         end_pend_q   <= end_pend_d;
         skid_full_q  <= skid_full_d;
         skid_data_q  <= skid_data_d;
         tmp_q        <= tmp_d;
         cnt_q        <= cnt_d;
         sum_q        <= sum_d;
         ptr_q        <= ptr_d;
         mem_addr_q   <= mem_addr_d;
         mem_dout_q   <= mem_dout_d;
         mem_wr_q     <= mem_wr_d;
         file_type_q  <= file_type_d;
         exec_addr_q  <= exec_addr_d;
         exec_valid_q <= exec_valid_d;
         block_cnt_q  <= block_cnt_d;
         done_q       <= done_d;
         chk_err_q    <= chk_err_d;
         fmt_err_q    <= fmt_err_d;
      end
   end

   assign ioctl_wait = mem_wr_q | skid_full_q;
   assign mem_addr   = mem_addr_q;
   assign mem_dout   = mem_dout_q;
   assign mem_wr     = mem_wr_q;
   assign file_type  = file_type_q;
   assign exec_addr  = exec_addr_q;
   assign exec_valid = exec_valid_q;
   assign block_cnt  = block_cnt_q;
   assign busy       = (state_q != S_IDLE) | mem_wr_q | skid_full_q;
   assign done       = done_q;
   assign chk_err    = chk_err_q;
   assign fmt_err    = fmt_err_q;

endmodule

// File: tb/tb_lynx_tap_loader.sv
// tb/tb_lynx_tap_loader.sv - directed self-checking bench for lynx_tap_loader
module tb_lynx_tap_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ioctl_download = 1'b0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = 25'd0;
   logic [7:0]  ioctl_dout = 8'h00;
   logic        ioctl_wait;
   logic [15:0] mem_addr;
   logic [7:0]  mem_dout;
   logic        mem_wr;
   logic        mem_ack;
   logic [7:0]  file_type;
   logic [15:0] exec_addr;
   logic        exec_valid;
   logic [3:0]  block_cnt;
   logic        busy, done, chk_err, fmt_err;

   int checks = 0;
   int failures = 0;
   int ack_delay = 1;
   int wait_cnt = 0;
   int wn = 0;
   int ev_cnt = 0;
   logic [15:0] waddr [64];
   logic [7:0]  wdata [64];
   logic        held = 1'b0;
   logic [23:0] held_val = 24'h0;

   lynx_tap_loader dut (
      .clk(clk), .reset(reset),
      .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
      .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_ack(mem_ack),
      .file_type(file_type), .exec_addr(exec_addr), .exec_valid(exec_valid),
      .block_cnt(block_cnt), .busy(busy), .done(done),
      .chk_err(chk_err), .fmt_err(fmt_err)
   );

   always #5 clk = ~clk;

   assign mem_ack = mem_wr && (wait_cnt >= ack_delay);

   always @(posedge clk) begin
      if (mem_wr && !mem_ack) wait_cnt <= wait_cnt + 1;
      else                    wait_cnt <= 0;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // RAM-side monitor: logs accepted writes and checks the held request stays stable.
   always @(negedge clk) begin
      if (exec_valid) ev_cnt++;
      if (mem_wr) begin
         if (held) check("wr_hold", {8'h0, mem_addr, mem_dout}, {8'h0, held_val});
         held_val = {mem_addr, mem_dout};
         held = !mem_ack;
         if (mem_ack && wn < 64) begin
            waddr[wn] = mem_addr;
            wdata[wn] = mem_dout;
            wn++;
         end
      end else begin
         held = 1'b0;
      end
   end

   task automatic send(input logic [7:0] b);
      int n = 0;
      while (ioctl_wait && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) check("wait_bound", 32'(n), 32'd0);
      ioctl_wr = 1'b1;
      ioctl_dout = b;
      @(posedge clk); #1;
      ioctl_wr = 1'b0;
   endtask

   task automatic send_hdr(input logic [7:0] t);
      send(8'h78); send(8'h78); send(8'h22);
      send(8'h4E); send(8'h41); send(8'h4D); send(8'h45); send(8'h22);
      send(8'hA5); send(8'hA5); send(t);
   endtask

   task automatic send_basic(input logic [7:0] c);
      send_hdr(8'h42);
      send(8'h05); send(8'h00);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      send(c); send(8'h00);
   endtask

   task automatic send_mc();
      send_hdr(8'h4D);
      send(8'h07); send(8'h00); send(8'h00); send(8'hC0); send(8'h34); send(8'h12);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      send(8'h0A); send(8'h00);
   endtask

   task automatic start_dl();
      @(posedge clk); #1;
      ioctl_download = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic end_dl();
      int n = 0;
      ioctl_download = 1'b0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (busy && n < 100);
      check("end_bound", 32'(busy), 32'd0);
   endtask

   task automatic expect_w(input int idx, input logic [15:0] a, input logic [7:0] d);
      check("w_addr", 32'(waddr[idx]), 32'(a));
      check("w_data", 32'(wdata[idx]), 32'(d));
   endtask

   int base, evb;

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      check("rst_flags", {25'h0, mem_wr, ioctl_wait, busy, done, chk_err, fmt_err, exec_valid}, 32'h0);
      check("rst_cnt_type", {20'h0, block_cnt, file_type}, 32'h0);
      check("rst_exec_addr", {exec_addr, mem_addr}, 32'h0);

      // BASIC block, good checksum
      base = wn; ack_delay = 1;
      start_dl();
      check("busy_after_start", 32'(busy), 32'd1);
      send_basic(8'hAA);
      end_dl();
      check("t1_nwr", 32'(wn - base), 32'd4);
      expect_w(base + 0, 16'h694D, 8'h11);
      expect_w(base + 1, 16'h694E, 8'h22);
      expect_w(base + 2, 16'h694F, 8'h33);
      expect_w(base + 3, 16'h6950, 8'h44);
      check("t1_status", {block_cnt, chk_err, fmt_err, done, file_type}, {4'd1, 3'b001, 8'h42});

      // Machine-code block with load and exec header
      base = wn; evb = ev_cnt;
      start_dl();
      check("t2_done_cleared", {block_cnt, done}, 5'h0);
      send_mc();
      end_dl();
      check("t2_nwr", 32'(wn - base), 32'd4);
      expect_w(base + 0, 16'hC000, 8'h01);
      expect_w(base + 3, 16'hC003, 8'h04);
      check("t2_exec", 32'(exec_addr), 32'h1234);
      check("t2_exec_pulses", 32'(ev_cnt - evb), 32'd1);
      check("t2_status", {block_cnt, chk_err, fmt_err, done, file_type}, {4'd1, 3'b001, 8'h4D});

      // Checksum mismatch still writes data
      base = wn;
      start_dl();
      send_basic(8'h00);
      end_dl();
      check("t3_nwr", 32'(wn - base), 32'd4);
      expect_w(base + 3, 16'h6950, 8'h44);
      check("t3_status", {block_cnt, chk_err, fmt_err, done}, {4'd1, 3'b101});

      // Back-pressure: host strobes every cycle ignoring wait
      base = wn; ack_delay = 5;
      start_dl();
      send_hdr(8'h42); send(8'h05); send(8'h00);
      ioctl_wr = 1'b1; ioctl_dout = 8'h11; @(posedge clk); #1;
      ioctl_dout = 8'h22; @(posedge clk); #1;
      check("t4_no_err_yet", 32'(fmt_err), 32'd0);
      ioctl_dout = 8'h33; @(posedge clk); #1;
      ioctl_wr = 1'b0;
      check("t4_wait_fmt", {ioctl_wait, fmt_err, busy}, 3'b111);
      send(8'h44); send(8'h55); send(8'hCC); send(8'h00);
      end_dl();
      check("t4_nwr", 32'(wn - base), 32'd4);
      expect_w(base + 0, 16'h694D, 8'h11);
      expect_w(base + 1, 16'h694E, 8'h22);
      expect_w(base + 2, 16'h694F, 8'h44);
      expect_w(base + 3, 16'h6950, 8'h55);
      check("t4_status", {block_cnt, chk_err, fmt_err, done}, {4'd1, 3'b011});

      // Two concatenated blocks, same-cycle ack
      base = wn; ack_delay = 0;
      start_dl();
      send_basic(8'hAA);
      send_mc();
      end_dl();
      check("t5_nwr", 32'(wn - base), 32'd8);
      expect_w(base + 0, 16'h694D, 8'h11);
      expect_w(base + 4, 16'hC000, 8'h01);
      expect_w(base + 7, 16'hC003, 8'h04);
      check("t5_status", {block_cnt, chk_err, fmt_err, done, file_type}, {4'd2, 3'b001, 8'h4D});

      // Zero-length bodies: BASIC len 1 and MC len 3 go straight to checksum
      base = wn; evb = ev_cnt;
      start_dl();
      send_hdr(8'h42); send(8'h01); send(8'h00); send(8'h00); send(8'h00);
      send_hdr(8'h4D); send(8'h03); send(8'h00); send(8'h00); send(8'h80);
      send(8'h78); send(8'h56); send(8'h00); send(8'h00);
      end_dl();
      check("t6_nwr", 32'(wn - base), 32'd0);
      check("t6_exec", {exec_addr, 16'(ev_cnt - evb)}, {16'h5678, 16'd1});
      check("t6_status", {block_cnt, chk_err, fmt_err, done}, {4'd2, 3'b001});

      // Truncation during DATA with a write still pending
      base = wn; ack_delay = 3;
      start_dl();
      send_hdr(8'h42); send(8'h05); send(8'h00); send(8'h11); send(8'h22);
      check("t7_pending", 32'(mem_wr), 32'd1);
      end_dl();
      check("t7_nwr", 32'(wn - base), 32'd2);
      expect_w(base + 1, 16'h694E, 8'h22);
      check("t7_status", {block_cnt, fmt_err, done, busy}, {4'd0, 3'b100});

      // Asynchronous reset while a write is pending
      ack_delay = 5;
      start_dl();
      send_hdr(8'h42); send(8'h05); send(8'h00); send(8'h11);
      #2 reset = 1'b1;
      #1 check("t8_async_rst", {mem_wr, busy, ioctl_wait, fmt_err, block_cnt, file_type}, 16'h0);
      ioctl_download = 1'b0;
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lynx_tap_loader.md
Name: lynx_tap_loader

Overview:
- Parametrised successor to the single-block TAP cassette parser.
- Parses a Lynx TAP image arriving on the MiSTer ioctl download stream and writes program bytes into system RAM.
- Adds concatenated multi-block support, honoured header load addresses, checksum verification, exec-address reporting, and a memory-side ack handshake with ioctl back-pressure.
- Sits between hps_io download and the RAM arbiter.

Parameters:
- ADDR_W, 16, width of mem_addr.
- DEFAULT_LOAD, 16'h694D, load address for 'B' blocks, and for all blocks when FORCE_LOAD=1.
- FORCE_LOAD, 0, 1 = ignore header load point and use DEFAULT_LOAD.
- BASIC_TYPE, 8'h42, file-type byte meaning BASIC (no load/exec header).
- SYNC_BYTE, 8'hA5, filler byte skipped before the type byte.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- ioctl_download  in  1  download window.
- ioctl_wr  in  1  byte strobe, one cycle.
- ioctl_addr  in  25  byte offset (debug only).
- ioctl_dout  in  8  download byte.
- ioctl_wait  out  1  back-pressure to hps_io.
- mem_addr  out  ADDR_W  RAM write address.
- mem_dout  out  8  RAM write data.
- mem_wr  out  1  write request, held until ack.
- mem_ack  in  1  RAM accepted the write.
- file_type  out  8  type byte of the last block.
- exec_addr  out  16  exec address of the last non-BASIC block.
- exec_valid  out  1  one-cycle pulse when exec_addr is updated.
- block_cnt  out  4  completed blocks, saturating at 15.
- busy  out  1  state not IDLE, or write pending.
- done  out  1  set at end of download if at least one block completed.
- chk_err  out  1  sticky checksum mismatch.
- fmt_err  out  1  sticky truncation or overrun.

Behaviour:
- Reset: all outputs 0, state IDLE, skid buffer empty.
- Download start (rising edge of ioctl_download):
  - Clear done, chk_err, fmt_err, block_cnt and the skid buffer.
  - Go to SEEK.
- A byte is consumed when the ioctl_wr strobe is seen, or when the skid buffer drains. One byte is consumed per cycle at most.
- States, with transitions taken on each consumed byte:
  - SEEK: on 8'h22, go to NAME.
  - NAME: on 8'h22, go to TYPE.
  - TYPE: SYNC_BYTE stays in TYPE. Any other byte is latched to file_type; go to LENLO.
  - LENLO: latch L[7:0]; go to LENHI.
  - LENHI: latch L[15:8].
    - If type==BASIC_TYPE: ptr=DEFAULT_LOAD, N=L-1, go to DATA (or CHK if N<=0).
    - Otherwise go to LDLO.
  - LDLO, then LDHI: latch the header load point. ptr = FORCE_LOAD ? DEFAULT_LOAD : header value.
  - EXLO, then EXHI: latch exec address. On EXHI, exec_addr updates and exec_valid pulses. N=L-3; go to DATA (or CHK if N<=0).
  - DATA: for each byte:
    - Issue write at ptr[ADDR_W-1:0].
    - ptr+1, wrapping mod 2^ADDR_W.
    - sum += byte, mod 256.
    - N-1. When N reaches 0, go to CHK.
  - CHK: compare the byte with sum. On mismatch set chk_err. Go to TAIL.
  - TAIL: consume one byte; block_cnt+1; sum=0; go to SEEK, which allows concatenated blocks.
- N and sum are held signed 17-bit and 8-bit respectively. L < 1 ('B') or L < 3 (other) is treated as N<=0.
- Write handshake:
  - mem_wr rises the cycle after the byte is consumed.
  - mem_addr and mem_dout stay stable while mem_wr is high.
  - mem_wr drops in the cycle after mem_ack is sampled high.
  - Ack in the same cycle mem_wr rises counts as accepted.
- ioctl_wait is high while mem_wr is high or the skid buffer is full.
- If ioctl_wr arrives while a write is pending, the byte goes into a 1-entry skid buffer. It is processed the cycle after the pending write completes.
- If ioctl_wr arrives while the skid buffer is full, set fmt_err and drop the byte.
- Download end (falling edge of ioctl_download):
  - The pending write and the skid byte still complete.
  - If state is not SEEK/IDLE, set fmt_err.
  - Go to IDLE; done = (block_cnt != 0).
- Reset mid-operation: reset asynchronously; mem_wr drops immediately.
- ioctl_wr with ioctl_download low is ignored.

Test Plan:
- BASIC block: "xx"\"NAME\"", A5 A5, 42, len 05 00, data 11 22 33 44, chk AA, tail 00 → writes 11/22/33/44 at 694D..6950; block_cnt=1; chk_err=0; done=1.
- Machine-code block, FORCE_LOAD=0: type 4D, len 07 00, load 00 C0, exec 34 12, data 01 02 03 04, chk 0A, tail → writes at C000..C003; exec_addr=1234 with one exec_valid pulse.
- Checksum error: same as the first scenario with chk 00 → all data still written; chk_err=1.
- Back-pressure: mem_ack delayed 5 cycles, host strobes every cycle ignoring wait → one byte held in the skid buffer, then processed; the third strobe sets fmt_err; the write order is preserved.
- Two concatenated blocks (BASIC then MC) → block_cnt=2; file_type=4D; writes go to both regions.
- Truncation: download drops during DATA after 2 bytes → 2 writes complete; fmt_err=1; done=0; state IDLE.
